gemm_seq_ctrl: RTL and testbench

Sequencer computing R = alpha*(A x B) + beta*C with one shared multiply-accumulate datapath, one output element at a time.
- Walks the i/j/k loop nest and issues read addresses to A, B and C operand buffers (1-cycle read latency).
- Accumulates products, scales the result, and writes each result element through a valid/ready write port.
- Sits between the host start/done interface and the operand/result buffers.

---
 rtl/gemm_pkg.sv | 23 ++
 rtl/gemm_mac_unit.sv | 40 ++++
 rtl/gemm_seq_ctrl.sv | 158 +++++++++++++++
 tb/tb_gemm_seq_ctrl.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/gemm_pkg.sv
// Shared types and helpers for the GEMM sequencer: FSM state encoding, default widths,
// and row-major address computation.
package gemm_pkg;

    localparam int unsigned DefDataWidth = 32;
    localparam int unsigned DefAddrWidth = 8;

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StAcc,
        StCfetch,
        StScale,
        StWrite,
        StDone
    } gemm_state_e;

    function automatic int unsigned calc_addr(input int unsigned row, input int unsigned col,
                                              input int unsigned stride);
        return row * stride + col;
    endfunction

endpackage

// File: rtl/gemm_mac_unit.sv
// Registered multiply-accumulate plus scale stage: acc += a*b, then result = alpha*acc + beta*c.
// All arithmetic wraps modulo 2^DATA_WIDTH.
module gemm_mac_unit
    import gemm_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DefDataWidth
) (
    input  logic                  iclk,
    input  logic                  irst,
    input  logic                  clr,
    input  logic                  acc_en,
    input  logic                  scale_en,
    input  logic [DATA_WIDTH-1:0] a_data,
    input  logic [DATA_WIDTH-1:0] b_data,
    input  logic [DATA_WIDTH-1:0] c_data,
    input  logic [DATA_WIDTH-1:0] alpha,
    input  logic [DATA_WIDTH-1:0] beta,
    output logic [DATA_WIDTH-1:0] result
);

    logic [DATA_WIDTH-1:0] acc_q;

    always_ff @(posedge iclk) begin
        if (irst) begin
            acc_q  <= '0;
            result <= '0;
        end else begin
            if (clr) begin
                acc_q <= '0;
            end else if (acc_en) begin
                acc_q <= acc_q + a_data * b_data;
            end
            // result is the write-port data and must hold until the next scale
            if (scale_en) begin
                result <= alpha * acc_q + beta * c_data;
            end
        end
    end

endmodule

// File: rtl/gemm_seq_ctrl.sv
// GEMM sequencer: walks i/j/k, issues operand reads, drives the shared MAC and
// writes R = alpha*(A x B) + beta*C one element at a time over a valid/ready port.
module gemm_seq_ctrl
    import gemm_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DefDataWidth,
    parameter int unsigned M          = 4,
    parameter int unsigned N          = 4,
    parameter int unsigned K          = 4,
    parameter int unsigned ADDR_WIDTH = DefAddrWidth
) (
    input  logic                  iclk,
    input  logic                  irst,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] alpha,
    input  logic [DATA_WIDTH-1:0] beta,
    output logic                  busy,
    output logic                  done,
    output logic                  rd_en,
    output logic [ADDR_WIDTH-1:0] a_addr,
    output logic [ADDR_WIDTH-1:0] b_addr,
    output logic [ADDR_WIDTH-1:0] c_addr,
    input  logic [DATA_WIDTH-1:0] a_data,
    input  logic [DATA_WIDTH-1:0] b_data,
    input  logic [DATA_WIDTH-1:0] c_data,
    output logic                  wr_valid,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  wr_ready
);

    if (M == 0 || N == 0 || K == 0) begin : g_bad_dims
        $error("gemm_seq_ctrl: M, N and K must all be non-zero");
    end

    localparam int unsigned IW = (M > 1) ? $clog2(M) : 1;
    localparam int unsigned JW = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned KW = (K > 1) ? $clog2(K) : 1;

    localparam logic [IW-1:0] ILast = IW'(M - 1);
    localparam logic [JW-1:0] JLast = JW'(N - 1);
    localparam logic [KW-1:0] KLast = KW'(K - 1);

    gemm_state_e           state;
    logic [IW-1:0]         i_q, i_nx;
    logic [JW-1:0]         j_q, j_nx;
    logic [KW-1:0]         k_q;
    logic [DATA_WIDTH-1:0] alpha_q, beta_q;
    logic                  last_elem;
    logic                  mac_clr, mac_acc, mac_scale;

    always_comb begin
        j_nx      = (j_q == JLast) ? '0 : j_q + JW'(1);
        i_nx      = (j_q == JLast) ? i_q + IW'(1) : i_q;
        last_elem = (i_q == ILast) && (j_q == JLast);
    end

    assign mac_clr   = ((state == StIdle) && start) || ((state == StWrite) && wr_ready);
    assign mac_acc   = (state == StAcc);
    assign mac_scale = (state == StScale);

    // Outputs are registered, so each transition loads the values the next state presents.
    always_ff @(posedge iclk) begin
        if (irst) begin
            state    <= StIdle;
            i_q      <= '0;
            j_q      <= '0;
            k_q      <= '0;
            alpha_q  <= '0;
            beta_q   <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            rd_en    <= 1'b0;
            a_addr   <= '0;
            b_addr   <= '0;
            c_addr   <= '0;
            wr_valid <= 1'b0;
            wr_addr  <= '0;
        end else begin
            done  <= 1'b0;
            rd_en <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (start) begin
                        alpha_q <= alpha;
                        beta_q  <= beta;
                        i_q     <= '0;
                        j_q     <= '0;
                        k_q     <= '0;
                        busy    <= 1'b1;
                        rd_en   <= 1'b1;
                        a_addr  <= '0;
                        b_addr  <= '0;
                        state   <= StFetch;
                    end
                end
                StFetch: state <= StAcc;
                StAcc: begin
                    rd_en <= 1'b1;
                    if (k_q == KLast) begin
                        k_q    <= '0;
                        c_addr <= ADDR_WIDTH'(calc_addr(32'(i_q), 32'(j_q), N));
                        state  <= StCfetch;
                    end else begin
                        k_q    <= k_q + KW'(1);
                        a_addr <= ADDR_WIDTH'(calc_addr(32'(i_q), 32'(k_q) + 32'd1, K));
                        b_addr <= ADDR_WIDTH'(calc_addr(32'(k_q) + 32'd1, 32'(j_q), N));
                        state  <= StFetch;
                    end
                end
                StCfetch: state <= StScale;
                StScale: begin
                    wr_addr  <= ADDR_WIDTH'(calc_addr(32'(i_q), 32'(j_q), N));
                    wr_valid <= 1'b1;
                    state    <= StWrite;
                end
                StWrite: begin
                    if (wr_ready) begin
                        wr_valid <= 1'b0;
                        if (last_elem) begin
                            done  <= 1'b1;
                            state <= StDone;
                        end else begin
                            i_q    <= i_nx;
                            j_q    <= j_nx;
                            rd_en  <= 1'b1;
                            a_addr <= ADDR_WIDTH'(calc_addr(32'(i_nx), 32'd0, K));
                            b_addr <= ADDR_WIDTH'(calc_addr(32'd0, 32'(j_nx), N));
                            state  <= StFetch;
                        end
                    end
                end
                StDone: begin
                    busy  <= 1'b0;
                    state <= StIdle;
                end
                default: state <= StIdle;
            endcase
        end
    end

    gemm_mac_unit #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_mac (
        .iclk    (iclk),
        .irst    (irst),
        .clr     (mac_clr),
        .acc_en  (mac_acc),
        .scale_en(mac_scale),
        .a_data  (a_data),
        .b_data  (b_data),
        .c_data  (c_data),
        .alpha   (alpha_q),
        .beta    (beta_q),
        .result  (wr_data)
    );

endmodule

// File: tb/tb_gemm_seq_ctrl.sv
// Directed bench for gemm_seq_ctrl (4x4x4): uniform-matrix vector table plus hand sequences
// for identity/latency, backpressure, start-while-busy and mid-operation reset.
module tb_gemm_seq_ctrl;

    logic        iclk = 1'b0;
    logic        irst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] alpha = '0;
    logic [31:0] beta = '0;
    logic        busy, done, rd_en, wr_valid;
    logic [7:0]  a_addr, b_addr, c_addr, wr_addr;
    logic [31:0] a_data = '0, b_data = '0, c_data = '0, wr_data;
    logic        wr_ready = 1'b1;

    logic [31:0] a_mem [256];
    logic [31:0] b_mem [256];
    logic [31:0] c_mem [256];

    logic [7:0]  log_addr [256];
    logic [31:0] log_data [256];
    logic [7:0]  wr_cnt = '0;
    int          done_cnt = 0;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [31:0] a, b, c, al, be, r;
    } vec_t;
    vec_t vecs [6];

    gemm_seq_ctrl dut (
        .iclk    (iclk),
        .irst    (irst),
        .start   (start),
        .alpha   (alpha),
        .beta    (beta),
        .busy    (busy),
        .done    (done),
        .rd_en   (rd_en),
        .a_addr  (a_addr),
        .b_addr  (b_addr),
        .c_addr  (c_addr),
        .a_data  (a_data),
        .b_data  (b_data),
        .c_data  (c_data),
        .wr_valid(wr_valid),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .wr_ready(wr_ready)
    );

    always #5 iclk = ~iclk;

    // Operand buffers with one cycle of read latency.
    always @(posedge iclk) begin
        if (rd_en) begin
            a_data <= a_mem[a_addr];
            b_data <= b_mem[b_addr];
            c_data <= c_mem[c_addr];
        end
    end

    always @(posedge iclk) begin
        if (!irst && wr_valid && wr_ready) begin
            log_addr[wr_cnt] <= wr_addr;
            log_data[wr_cnt] <= wr_data;
            wr_cnt <= wr_cnt + 8'd1;
        end
        if (!irst && done) done_cnt <= done_cnt + 1;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic fill_uniform(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
        for (int e = 0; e < 16; e++) begin
            a_mem[e] = a;
            b_mem[e] = b;
            c_mem[e] = c;
        end
    endtask

    // A = I, B[k][j] = k*4+j, C[e] = c0 + e
    task automatic fill_identity(input logic [31:0] c0);
        for (int e = 0; e < 16; e++) begin
            a_mem[e] = ((e / 4) == (e % 4)) ? 32'd1 : 32'd0;
            b_mem[e] = 32'(e);
            c_mem[e] = c0 + 32'(e);
        end
    endtask

    // Called at a negedge; returns at a negedge one cycle past done (or right after a reset).
    // Cycle n is the cycle following the n-th rising edge counted from the edge sampling start.
    task automatic run_op(input logic [31:0] al, input logic [31:0] be, input int stall_elem,
                          input int stall_n, input int dup_cyc, input int rst_cyc,
                          output int done_cyc, output int wv_cyc, output logic [7:0] base);
        int          stalls;
        bit          holding;
        logic [7:0]  hold_a;
        logic [31:0] hold_d;
        stalls   = 0;
        holding  = 0;
        hold_a   = '0;
        hold_d   = '0;
        base     = wr_cnt;
        done_cyc = -1;
        wv_cyc   = -1;
        alpha    = al;
        beta     = be;
        start    = 1'b1;
        for (int n = 1; n <= 400; n++) begin
            @(negedge iclk);
            start = 1'b0;
            alpha = 32'h5A5A_0F0F;
            beta  = 32'hC3C3_1234;
            if (n == dup_cyc) begin
                start = 1'b1;
                alpha = 32'd9;
                beta  = 32'd9;
            end
            if (n == rst_cyc) begin
                irst = 1'b1;
                @(negedge iclk);
                chk("reset_outputs", 64'({busy, done, rd_en, a_addr, b_addr, c_addr, wr_valid,
                                          wr_addr}), 64'd0);
                chk("reset_wr_data", 64'(wr_data), 64'd0);
                irst = 1'b0;
                return;
            end
            if (wr_valid && wv_cyc < 0) wv_cyc = n;
            if (done) begin
                done_cyc = n;
                wr_ready = 1'b1;
                break;
            end
            if (wr_valid && int'(wr_cnt - base) == stall_elem) begin
                if (!holding) begin
                    holding = 1;
                    hold_a  = wr_addr;
                    hold_d  = wr_data;
                end else begin
                    chk("stall_hold_addr", 64'(wr_addr), 64'(hold_a));
                    chk("stall_hold_data", 64'(wr_data), 64'(hold_d));
                end
            end
            if (wr_valid && int'(wr_cnt - base) == stall_elem && stalls < stall_n) begin
                stalls++;
                wr_ready = 1'b0;
            end else begin
                wr_ready = 1'b1;
            end
        end
        @(negedge iclk);
    endtask

    task automatic check_writes(input string name, input logic [7:0] base,
                                input logic [31:0] r_const, input logic [31:0] r_step);
        chk({name, "_count"}, 64'(wr_cnt - base), 64'd16);
        for (int e = 0; e < 16; e++) begin
            chk({name, "_addr"}, 64'(log_addr[base + 8'(e)]), 64'(e));
            chk({name, "_data"}, 64'(log_data[base + 8'(e)]), 64'(r_const + r_step * 32'(e)));
        end
    endtask

    initial begin
        int         dcyc, wcyc, dbefore;
        logic [7:0] base;

        vecs[0] = '{32'd2, 32'd2, 32'd5, 32'd3, 32'd2, 32'd58};
        vecs[1] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd1, 32'd0, 32'd4};
        vecs[2] = '{32'd1, 32'd1, 32'd1, 32'd1, 32'd1, 32'd5};
        vecs[3] = '{32'h0001_0000, 32'h0001_0000, 32'd7, 32'd1, 32'd3, 32'd21};
        vecs[4] = '{32'd3, 32'd5, 32'h8000_0000, 32'd2, 32'd2, 32'd120};
        vecs[5] = '{32'd0, 32'd7, 32'd9, 32'd5, 32'd4, 32'd36};

        repeat (3) @(negedge iclk);
        chk("reset_state", 64'({busy, done, rd_en, a_addr, b_addr, c_addr, wr_valid, wr_addr}),
            64'd0);
        irst = 1'b0;
        @(negedge iclk);

        // Identity: R = B; first write in cycle 11, and 16 elements x 11 cycles fill
        // cycles 1..176 so the DONE pulse lands in cycle 177.
        fill_identity(32'd0);
        run_op(32'd1, 32'd0, -1, 0, -1, -1, dcyc, wcyc, base);
        chk("ident_first_wr_valid_cycle", 64'(wcyc), 64'd11);
        chk("ident_done_cycle", 64'(dcyc), 64'd177);
        check_writes("ident", base, 32'd0, 32'd1);
        chk("ident_busy_after", 64'(busy), 64'd0);

        for (int v = 0; v < 6; v++) begin
            fill_uniform(vecs[v].a, vecs[v].b, vecs[v].c);
            run_op(vecs[v].al, vecs[v].be, -1, 0, -1, -1, dcyc, wcyc, base);
            chk("vec_done_cycle", 64'(dcyc), 64'd177);
            check_writes("vec", base, vecs[v].r, 32'd0);
        end

        // Backpressure on element 5 for 3 cycles; R = 2*B + (100+e) = 3e + 100.
        fill_identity(32'd100);
        run_op(32'd2, 32'd1, 5, 3, -1, -1, dcyc, wcyc, base);
        chk("stall_done_cycle", 64'(dcyc), 64'd180);
        check_writes("stall", base, 32'd100, 32'd3);

        // Second start at cycle 20 with alpha=9 must be ignored.
        dbefore = done_cnt;
        run_op(32'd2, 32'd1, -1, 0, 20, -1, dcyc, wcyc, base);
        chk("dup_done_cycle", 64'(dcyc), 64'd177);
        check_writes("dup", base, 32'd100, 32'd3);
        repeat (30) @(negedge iclk);
        chk("dup_single_done", 64'(done_cnt - dbefore), 64'd1);
        chk("dup_no_extra_writes", 64'(wr_cnt - base), 64'd16);
        chk("dup_idle_after", 64'(busy), 64'd0);

        // Reset at cycle 50: elements 0..3 already written (cycles 11, 22, 33, 44).
        fill_identity(32'd0);
        dbefore = done_cnt;
        run_op(32'd1, 32'd0, -1, 0, -1, 50, dcyc, wcyc, base);
        repeat (20) @(negedge iclk);
        chk("rst_writes_before_abort", 64'(wr_cnt - base), 64'd4);
        chk("rst_no_done", 64'(done_cnt - dbefore), 64'd0);
        chk("rst_idle", 64'({busy, wr_valid, rd_en}), 64'd0);
        run_op(32'd1, 32'd0, -1, 0, -1, -1, dcyc, wcyc, base);
        chk("rst_fresh_done_cycle", 64'(dcyc), 64'd177);
        check_writes("rst_fresh", base, 32'd0, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
